// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// DMEM_WAIT_EN (in dmem_responder) adds programmable wait states.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    // Alignment check only; the illegal size code is rejected separately.
    function automatic logic misaligned(input size_t sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; used by dmem_responder.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        be      = '0;
        wlane   = '0;
        rdata   = '0;
        shifted = rword >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wlane = {4{wdata[7:0]}};
                rdata = unsigned_ld ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                rdata = unsigned_ld ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be    = '1;
                wlane = wdata;
                rdata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-access data-memory responder with stall, byte/half/word accesses.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES extra latency cycles per access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] ddata_w,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    output logic [DATA_W-1:0] ddata_r,
    output logic              ready,
    output logic              err,
    output logic              stall
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, next;

    logic [AW+1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    size_t             size_q;
    logic              uns_q, rd_q, wr_q, bad_q;

    logic              req, bad_in, enter_resp;
    size_t             size_in;

    logic [AW+1:0]     cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    size_t             cur_size;
    logic              cur_uns, cur_rd, cur_wr, cur_bad;

    logic [AW-1:0]     idx;
    logic [31:0]       rword, wlane, rdata;
    logic [3:0]        be;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              unused_addr;
    assign unused_addr = ^daddr[DATA_W-1:AW+2];

`ifdef DMEM_WAIT_EN
    localparam int CW = $clog2(WAIT_CYCLES + 1) + 1;
    logic [CW-1:0] wait_cnt;
`endif

    assign req     = MemRead | MemWrite;
    assign size_in = size_t'(size);
    assign bad_in  = (MemRead & MemWrite) | (size_in == SZ_ILL)
                   | misaligned(size_in, daddr[1:0]);
    assign stall   = ((state == IDLE) & req) | (state == WAIT);

    // Without wait states the RAM access coincides with the accept edge, so
    // the live inputs are used in IDLE and the latched copies afterwards.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = daddr[AW+1:0];
            cur_wdata = ddata_w;
            cur_size  = size_in;
            cur_uns   = unsigned_ld;
            cur_rd    = MemRead;
            cur_wr    = MemWrite;
            cur_bad   = bad_in;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_bad   = bad_q;
        end
    end

    assign idx   = cur_addr[AW+1:2];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .addr_lo     (cur_addr[1:0]),
        .size        (cur_size),
        .unsigned_ld (cur_uns),
        .wdata       (cur_wdata),
        .rword       (rword),
        .be          (be),
        .wlane       (wlane),
        .rdata       (rdata)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef DMEM_WAIT_EN
                    next = (WAIT_CYCLES == 0) ? RESP : WAIT;
`else
                    next = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_EN
                if (wait_cnt == '0) next = RESP;
`else
                next = IDLE;
`endif
            end
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign enter_resp = (next == RESP);

    // RESET gating keeps an aborted access from writing on a reset edge.
    always_ff @(posedge CLK) begin
        if (enter_resp && cur_wr && !cur_bad && !RESET) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            ddata_r <= '0;
        end else begin
            state <= next;
            if (state == IDLE && req) begin
                addr_q  <= daddr[AW+1:0];
                wdata_q <= ddata_w;
                size_q  <= size_in;
                uns_q   <= unsigned_ld;
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
                bad_q   <= bad_in;
            end
            ready   <= enter_resp;
            err     <= enter_resp & cur_bad;
            ddata_r <= (enter_resp && cur_rd && !cur_bad) ? rdata : '0;
        end
    end

`ifdef DMEM_WAIT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else if (state == IDLE && req) begin
            wait_cnt <= (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`endif

endmodule
